// File: rtl/fc0_seq_ctrl_if.sv
// Bus bundle for fc0_seq_ctrl: start/hold level, shared memory read port, bias and result.
// The sat_flag member exists only when FC_SAT_EN is defined.
interface fc0_seq_ctrl_if #(
  parameter int IN_W   = 30,
  parameter int W_W    = 9,
  parameter int ACC_W  = 38,
  parameter int ADDR_W = 12
);
  logic                     enable;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [IN_W-1:0]   input7_q;
  logic signed [W_W-1:0]    w_q;
  logic signed [W_W-1:0]    b;
  logic signed [ACC_W-1:0]  output7;
  logic                     done_fc0;
  logic                     busy;
`ifdef FC_SAT_EN
  logic                     sat_flag;

  modport master (
    input  enable, input7_q, w_q, b,
    output rd_en, rd_addr, output7, done_fc0, busy, sat_flag
  );
  modport slave (
    output enable, input7_q, w_q, b,
    input  rd_en, rd_addr, output7, done_fc0, busy, sat_flag
  );
`else
  modport master (
    input  enable, input7_q, w_q, b,
    output rd_en, rd_addr, output7, done_fc0, busy
  );
  modport slave (
    output enable, input7_q, w_q, b,
    input  rd_en, rd_addr, output7, done_fc0, busy
  );
`endif
endinterface

// File: rtl/fc0_seq_ctrl.sv
// fc0 neuron sequencer: streams N_IN activation/weight pairs through one signed MAC, adds bias.
// Optional FC_SAT_EN: saturating accumulate/bias add plus a sticky sat_flag output.
module fc0_seq_ctrl #(
  parameter int N_IN   = 3136,
  parameter int IN_W   = 30,
  parameter int W_W    = 9,
  parameter int ACC_W  = 38,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  fc0_seq_ctrl_if.master  bus
);

  localparam int PROD_W = IN_W + W_W;
  localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, BIAS, DONE} state_e;

  state_e                   state_q, state_d;
  logic                     rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [RD_LAT-1:0]        mac_v_q, mac_v_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  output7_q, output7_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  addend;
  logic signed [ACC_W-1:0]  acc_next;

  // One adder serves both the MAC stream and the bias step; BIAS never overlaps a valid beat.
  always_comb begin
    prod   = PROD_W'(bus.input7_q) * PROD_W'(bus.w_q);
    addend = SUM_W'(prod);
    if (state_q == BIAS) addend = SUM_W'(bus.b);
  end

`ifdef FC_SAT_EN
  logic                    sat_q, sat_d;
  logic signed [SUM_W-1:0] acc_sum;
  logic                    acc_ovf;

  always_comb begin
    acc_sum  = SUM_W'(acc_q) + addend;
    acc_ovf  = acc_sum[SUM_W-1:ACC_W-1] != {(SUM_W-ACC_W+1){acc_sum[SUM_W-1]}};
    acc_next = acc_ovf ? {acc_sum[SUM_W-1], {(ACC_W-1){~acc_sum[SUM_W-1]}}}
                       : acc_sum[ACC_W-1:0];
  end
`else
  assign acc_next = acc_q + ACC_W'(addend);
`endif

  // NOTE: every _d gets a default first so this block cannot infer a latch.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    mac_v_d   = mac_v_q << 1;
    mac_v_d[0] = rd_en_q;
    acc_d     = acc_q;
    output7_d = output7_q;
    done_d    = done_q;
    busy_d    = busy_q;
`ifdef FC_SAT_EN
    sat_d     = sat_q;
    if ((mac_v_q[RD_LAT-1] || state_q == BIAS) && acc_ovf) sat_d = 1'b1;
`endif

    if (mac_v_q[RD_LAT-1]) acc_d = acc_next;

    unique case (state_q)
      IDLE: begin
        acc_d     = '0;
        mac_v_d   = '0;
        output7_d = '0;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        if (bus.enable) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
`ifdef FC_SAT_EN
          sat_d   = 1'b0;
`endif
        end
      end
      FETCH: begin
        rd_en_d   = 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == LAST_ADDR) begin
          state_d   = DRAIN;
          rd_en_d   = 1'b0;
          rd_addr_d = '0;
        end
      end
      // Leave only once the final product is already in acc_q.
      DRAIN: if (mac_v_q == '0) state_d = BIAS;
      BIAS: begin
        acc_d   = acc_next;
        state_d = DONE;
      end
      DONE: begin
        busy_d = 1'b0;
        if (bus.enable) begin
          output7_d = acc_q;
          done_d    = 1'b1;
        end else begin
          output7_d = '0;
          done_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort: flushing the valid pipeline drops any read data still in flight.
    if (!bus.enable && (state_q == FETCH || state_q == DRAIN || state_q == BIAS)) begin
      state_d   = IDLE;
      rd_en_d   = 1'b0;
      rd_addr_d = '0;
      mac_v_d   = '0;
      acc_d     = '0;
      busy_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      mac_v_q   <= '0;
      acc_q     <= '0;
      output7_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FC_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      mac_v_q   <= mac_v_d;
      acc_q     <= acc_d;
      output7_q <= output7_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef FC_SAT_EN
      sat_q     <= sat_d;
`endif
    end
  end

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.output7  = output7_q;
  assign bus.done_fc0 = done_q;
  assign bus.busy     = busy_q;
`ifdef FC_SAT_EN
  assign bus.sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_fc0_seq_ctrl.sv
// Bench for fc0_seq_ctrl: a 4-input instance for table vectors and corner sequences,
// a default-size instance for full latency/abort, and a 32-bit saturating one under FC_SAT_EN.
module tb_fc0_seq_ctrl;

  localparam int IN_W = 30;
  localparam int W_W  = 9;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fc0_seq_ctrl_if s_if ();
  fc0_seq_ctrl_if l_if ();

  fc0_seq_ctrl #(.N_IN(4)) u_small (.clk(clk), .rst(rst), .bus(s_if));
  fc0_seq_ctrl             u_large (.clk(clk), .rst(rst), .bus(l_if));

  logic signed [IN_W-1:0] s_act [4];
  logic signed [W_W-1:0]  s_wt  [4];

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    if (s_if.rd_en) begin
      s_if.input7_q <= s_act[s_if.rd_addr[1:0]];
      s_if.w_q      <= s_wt[s_if.rd_addr[1:0]];
    end
  end

`ifdef FC_SAT_EN
  fc0_seq_ctrl_if #(.ACC_W(32)) x_if ();
  fc0_seq_ctrl #(.N_IN(4), .ACC_W(32)) u_sat (.clk(clk), .rst(rst), .bus(x_if));

  always @(posedge clk) begin
    if (x_if.rd_en) begin
      x_if.input7_q <= s_act[x_if.rd_addr[1:0]];
      x_if.w_q      <= s_wt[x_if.rd_addr[1:0]];
    end
  end
`endif

  typedef struct packed {
    logic [3:0][IN_W-1:0] act;
    logic [3:0][W_W-1:0]  wt;
    logic [W_W-1:0]       bias;
    logic [63:0]          exp;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int w0, input int w1, input int w2, input int w3,
                              input int bias, input longint e);
    vec_t v;
    v.act[0] = IN_W'(a0); v.act[1] = IN_W'(a1); v.act[2] = IN_W'(a2); v.act[3] = IN_W'(a3);
    v.wt[0]  = W_W'(w0);  v.wt[1]  = W_W'(w1);  v.wt[2]  = W_W'(w2);  v.wt[3]  = W_W'(w3);
    v.bias   = W_W'(bias);
    v.exp    = e;
    return v;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_small(input vec_t v, input string tag);
    int   edge_n;
    int   addr_i;
    logic addr_ok;
    logic overlap;
    logic busy_prev;
    for (int i = 0; i < 4; i++) begin
      s_act[i] = v.act[i];
      s_wt[i]  = v.wt[i];
    end
    s_if.b      = v.bias;
    s_if.enable = 1'b1;
    edge_n = -1; addr_i = 0; addr_ok = 1'b1; overlap = 1'b0; busy_prev = 1'b0;
    while (!s_if.done_fc0 && edge_n < 50) begin
      busy_prev = s_if.busy;
      @(posedge clk); #1;
      edge_n++;
      if (s_if.rd_en) begin
        if (s_if.rd_addr != 12'(addr_i)) addr_ok = 1'b0;
        addr_i++;
      end
      if (s_if.busy && s_if.done_fc0) overlap = 1'b1;
    end
    check({tag, "_latency"}, edge_n, 8);
    check({tag, "_output7"}, s_if.output7, v.exp);
    check({tag, "_addr_seq"}, {addr_ok, 8'(addr_i)}, {1'b1, 8'd4});
    check({tag, "_busy_handoff"}, {busy_prev, s_if.busy, overlap}, 3'b100);
  endtask

  task automatic close_small(input string tag);
    s_if.enable = 1'b0;
    @(posedge clk); #1;
    check({tag, "_clear"}, {s_if.done_fc0, s_if.output7}, 0);
  endtask

  task automatic run_big(input string tag);
    int   edge_n;
    logic overlap;
    logic busy_prev;
    l_if.enable = 1'b1;
    edge_n = -1; overlap = 1'b0; busy_prev = 1'b0;
    while (!l_if.done_fc0 && edge_n < 4000) begin
      busy_prev = l_if.busy;
      @(posedge clk); #1;
      edge_n++;
      if (l_if.busy && l_if.done_fc0) overlap = 1'b1;
    end
    check({tag, "_latency"}, edge_n, 3140);
    check({tag, "_output7"}, l_if.output7, -3136);
    check({tag, "_busy_handoff"}, {busy_prev, l_if.busy, overlap}, 3'b100);
    l_if.enable = 1'b0;
    @(posedge clk); #1;
    check({tag, "_clear"}, {l_if.done_fc0, l_if.output7}, 0);
  endtask

`ifdef FC_SAT_EN
  task automatic run_sat(input int a, input int w, input longint e, input logic f, input string tag);
    int n;
    for (int i = 0; i < 4; i++) begin
      s_act[i] = IN_W'(a);
      s_wt[i]  = W_W'(w);
    end
    x_if.b      = '0;
    x_if.enable = 1'b1;
    n = 0;
    while (!x_if.done_fc0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_output7"}, x_if.output7, e);
    check({tag, "_sat_flag"}, x_if.sat_flag, f);
    x_if.enable = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stable;
    int n;

    vecs[0] = mk(1, 2, 3, 4,  1, 1, 1, 1,  5, 64'sd15);
    vecs[1] = mk(-1, -2, -3, -4,  2, 2, 2, 2,  0, -64'sd20);
    vecs[2] = mk(536870911, 536870911, 536870911, 0,  255, -255, 255, 0,  -256, 64'sd136902082049);
`ifdef FC_SAT_EN
    vecs[3] = mk(-536870912, 0, 0, 0,  -256, 0, 0, 0,  0, 64'sd137438953471);
`else
    vecs[3] = mk(-536870912, 0, 0, 0,  -256, 0, 0, 0,  0, -64'sd137438953472);
`endif
    vecs[4] = mk(0, 0, 0, 0,  0, 0, 0, 0,  -256, -64'sd256);
    vecs[5] = mk(7, -3, 100, -1000,  -5, 9, -128, 127,  3, -64'sd139859);

    rst = 1'b1;
    s_if.enable = 1'b0; s_if.b = '0;
    l_if.enable = 1'b0; l_if.b = '0;
    l_if.input7_q = 30'sd1;
    l_if.w_q      = -9'sd1;
`ifdef FC_SAT_EN
    x_if.enable = 1'b0; x_if.b = '0;
`endif
    #12;
    check("reset_small", {s_if.rd_en, s_if.rd_addr, s_if.output7, s_if.done_fc0, s_if.busy}, 0);
    check("reset_large", {l_if.rd_en, l_if.rd_addr, l_if.output7, l_if.done_fc0, l_if.busy}, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_small(vecs[i], $sformatf("vec%0d", i));
      close_small($sformatf("vec%0d", i));
    end

    // Hold with enable high: result frozen, no retrigger; then clear on enable low.
    run_small(vecs[0], "hold");
    stable = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (s_if.done_fc0 && !s_if.busy && !s_if.rd_en && s_if.output7 == 38'sd15) stable++;
    end
    check("hold_stable_cycles", stable, 50);
    close_small("hold");

    // Abort mid-fetch on the small instance, then a clean run.
    for (int i = 0; i < 4; i++) begin
      s_act[i] = vecs[5].act[i];
      s_wt[i]  = vecs[5].wt[i];
    end
    s_if.b = vecs[5].bias;
    s_if.enable = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_small_addr", s_if.rd_addr, 2);
    s_if.enable = 1'b0;
    @(posedge clk); #1;
    check("abort_small_idle", {s_if.rd_en, s_if.busy, s_if.done_fc0, s_if.rd_addr}, 0);
    @(posedge clk); #1;
    run_small(vecs[0], "after_abort");
    close_small("after_abort");

    // Asynchronous reset in FETCH, off the clock edge.
    s_if.enable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_reset_fetching", s_if.rd_en, 1);
    #3 rst = 1'b1;
    #1;
    check("reset_async", {s_if.rd_en, s_if.rd_addr, s_if.output7, s_if.done_fc0, s_if.busy}, 0);
    s_if.enable = 1'b0;
    @(posedge clk); #4 rst = 1'b0;
    @(posedge clk); #1;
    run_small(vecs[0], "after_reset");
    close_small("after_reset");

    // Full-size run, then abort at address 100 and a fresh run.
    run_big("large");
    l_if.enable = 1'b1;
    n = 0;
    while (l_if.rd_addr != 12'd100 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_large_addr", l_if.rd_addr, 100);
    l_if.enable = 1'b0;
    @(posedge clk); #1;
    check("abort_large_idle", {l_if.rd_en, l_if.busy, l_if.done_fc0}, 0);
    @(posedge clk); #1;
    run_big("large_restart");

`ifdef FC_SAT_EN
    run_sat(1000, 255, 64'sd1020000, 1'b0, "sat_fit");
    run_sat(536870911, 255, 64'sd2147483647, 1'b1, "sat_clamp");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
